instr_mem_fetch: RTL and testbench

- Parametrised instruction memory with a request/response fetch handshake, a programmable wait-state latency and a loader write port.
- Sits between the PC/fetch stage and the decoder. Replaces the combinational 256x32 instruction ROM.
- Can be loaded at runtime, so test programs need not be hard-coded.
- Flags misaligned and out-of-range fetches instead of aliasing them.

---
 rtl/instr_mem_fetch.sv | 161 ++++++++++++++++
 tb/tb_instr_mem_fetch.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_fetch.sv
// instr_mem_fetch: loadable instruction memory with a request/response fetch
// handshake and a fixed, parameterised number of wait states per fetch.
//
// Ports:
//   clk, reset            rising-edge clock, synchronous active-high reset
//   req_valid/req_ready   fetch request handshake (ready only while IDLE)
//   req_pc                byte address of the instruction to fetch
//   rsp_valid/rsp_ready   response handshake
//   rsp_instr             fetched word (0 when rsp_err is set)
//   rsp_pc                req_pc of the request being answered
//   rsp_err               misaligned or out-of-range fetch
//   ld_en/ld_addr/ld_data loader write port (word index), usable in any state
//   busy                  a fetch is in flight
module instr_mem_fetch #(
  parameter int DATA_W      = 32,
  parameter int ADDR_W      = 10,
  parameter int DEPTH       = 256,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_pc,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_instr,
  output logic [ADDR_W-1:0] rsp_pc,
  output logic              rsp_err,
  input  logic              ld_en,
  input  logic [ADDR_W-3:0] ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              busy
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  // One bit wider than a word index so DEPTH == 2^(ADDR_W-2) is representable.
  localparam logic [ADDR_W-2:0] DEPTH_LIM = DEPTH[ADDR_W-2:0];
  localparam logic [3:0]        WAIT_LD   = WAIT_CYCLES[3:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t              state_r;
  logic [3:0]          cnt_r;
  logic [ADDR_W-1:0]   pc_r;
  logic                rsp_valid_r;
  logic [DATA_W-1:0]   rsp_instr_r;
  logic [ADDR_W-1:0]   rsp_pc_r;
  logic                rsp_err_r;
  logic                busy_r;

  // Contents survive reset; they start as all-zero (NOP) at power-up.
  logic [DATA_W-1:0]   mem [DEPTH] = '{default: '0};

  logic [ADDR_W-1:0]   cap_pc_s;
  logic [ADDR_W-3:0]   cap_idx_s;
  logic                cap_err_s;
  logic [DATA_W-1:0]   cap_instr_s;
  logic                ld_ok_s;

  assign req_ready = (state_r == IDLE);
  assign rsp_valid = rsp_valid_r;
  assign rsp_instr = rsp_instr_r;
  assign rsp_pc    = rsp_pc_r;
  assign rsp_err   = rsp_err_r;
  assign busy      = busy_r;

  // Response capture source: the live request when there are no wait states,
  // otherwise the address latched at accept time.
  always_comb begin
    cap_pc_s    = pc_r;
    cap_instr_s = '0;
    if (state_r == IDLE) begin
      cap_pc_s = req_pc;
    end else begin
      cap_pc_s = pc_r;
    end
    cap_idx_s = cap_pc_s[ADDR_W-1:2];
    cap_err_s = (cap_pc_s[1:0] != 2'b00) || ({1'b0, cap_idx_s} >= DEPTH_LIM);
    // Non-blocking memory write below makes a same-edge collision read the old word.
    if (cap_err_s) begin
      cap_instr_s = '0;
    end else begin
      cap_instr_s = mem[cap_idx_s[IDX_W-1:0]];
    end
  end

  // Loader range check; out-of-range writes are dropped rather than aliased.
  always_comb begin
    ld_ok_s = ld_en && ({1'b0, ld_addr} < DEPTH_LIM);
  end

  // Loader write port; deliberately independent of reset and FSM state.
  always_ff @(posedge clk) begin
    if (ld_ok_s) begin
      mem[ld_addr[IDX_W-1:0]] <= ld_data;
    end
  end

  // Fetch FSM with registered response outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      pc_r        <= '0;
      rsp_valid_r <= 1'b0;
      rsp_instr_r <= '0;
      rsp_pc_r    <= '0;
      rsp_err_r   <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            pc_r   <= req_pc;
            cnt_r  <= WAIT_LD;
            busy_r <= 1'b1;
            if (WAIT_CYCLES == 0) begin
              state_r     <= RESP;
              rsp_valid_r <= 1'b1;
              rsp_instr_r <= cap_instr_s;
              rsp_pc_r    <= cap_pc_s;
              rsp_err_r   <= cap_err_s;
            end else begin
              state_r <= WAIT;
            end
          end
        end
        WAIT: begin
          cnt_r <= cnt_r - 4'd1;
          if (cnt_r == 4'd1) begin
            state_r     <= RESP;
            rsp_valid_r <= 1'b1;
            rsp_instr_r <= cap_instr_s;
            rsp_pc_r    <= cap_pc_s;
            rsp_err_r   <= cap_err_s;
          end
        end
        RESP: begin
          // Response data is left in place after the handshake.
          if (rsp_ready) begin
            state_r     <= IDLE;
            rsp_valid_r <= 1'b0;
            busy_r      <= 1'b0;
          end
        end
        default: begin
          state_r     <= IDLE;
          cnt_r       <= 4'd0;
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_mem_fetch.sv
// Testbench for instr_mem_fetch. Three instances share clock, reset, loader
// and response-ready: WAIT_CYCLES = 1 (main), 0 and 3. ADDR_W is 11 so that
// pc = 4*DEPTH = 0x400 is expressible and exercises the out-of-range path.
module tb_instr_mem_fetch;

  localparam int DW = 32;
  localparam int AW = 11;
  localparam int DP = 256;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] req_pc = '0;
  logic          rsp_ready = 1'b1;
  logic          ld_en = 1'b0;
  logic [AW-3:0] ld_addr = '0;
  logic [DW-1:0] ld_data = '0;

  logic          av = 1'b0, bv = 1'b0, cv = 1'b0;
  logic          a_rdy, b_rdy, c_rdy;
  logic          a_val, b_val, c_val;
  logic [DW-1:0] a_ins, b_ins, c_ins;
  logic [AW-1:0] a_pc, b_pc, c_pc;
  logic          a_err, b_err, c_err;
  logic          a_busy, b_busy, c_busy;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int exp_lat [3] = '{2, 1, 4};

  instr_mem_fetch #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .WAIT_CYCLES(1)) u_main (
    .clk(clk), .reset(reset), .req_valid(av), .req_ready(a_rdy), .req_pc(req_pc),
    .rsp_valid(a_val), .rsp_ready(rsp_ready), .rsp_instr(a_ins), .rsp_pc(a_pc),
    .rsp_err(a_err), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .busy(a_busy));

  instr_mem_fetch #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .WAIT_CYCLES(0)) u_w0 (
    .clk(clk), .reset(reset), .req_valid(bv), .req_ready(b_rdy), .req_pc(req_pc),
    .rsp_valid(b_val), .rsp_ready(rsp_ready), .rsp_instr(b_ins), .rsp_pc(b_pc),
    .rsp_err(b_err), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .busy(b_busy));

  instr_mem_fetch #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP), .WAIT_CYCLES(3)) u_w3 (
    .clk(clk), .reset(reset), .req_valid(cv), .req_ready(c_rdy), .req_pc(req_pc),
    .rsp_valid(c_val), .rsp_ready(rsp_ready), .rsp_instr(c_ins), .rsp_pc(c_pc),
    .rsp_err(c_err), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data), .busy(c_busy));

  always #5 clk = ~clk;

  // Posedge counter used to time accept edges.
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int            dut;
    logic [AW-1:0] pc;
    logic [DW-1:0] instr;
    logic          err;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic set_valid(input int w, input logic v);
    case (w)
      0: av = v;
      1: bv = v;
      default: cv = v;
    endcase
  endtask

  function automatic logic f_rdy(input int w);
    case (w)
      0: return a_rdy;
      1: return b_rdy;
      default: return c_rdy;
    endcase
  endfunction

  function automatic logic f_val(input int w);
    case (w)
      0: return a_val;
      1: return b_val;
      default: return c_val;
    endcase
  endfunction

  function automatic logic [DW-1:0] f_ins(input int w);
    case (w)
      0: return a_ins;
      1: return b_ins;
      default: return c_ins;
    endcase
  endfunction

  function automatic logic [AW-1:0] f_pc(input int w);
    case (w)
      0: return a_pc;
      1: return b_pc;
      default: return c_pc;
    endcase
  endfunction

  function automatic logic f_err(input int w);
    case (w)
      0: return a_err;
      1: return b_err;
      default: return c_err;
    endcase
  endfunction

  // Called and returns at a negedge; the response is left pending with rsp_ready high.
  task automatic do_fetch(input int w, input logic [AW-1:0] pc, input logic [DW-1:0] ei,
                          input logic ee, input string nm);
    int n;
    int lat;
    req_pc = pc;
    set_valid(w, 1'b1);
    n = 0;
    while (!f_rdy(w) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({nm, " accepted"}, 32'(n < 20), 32'd1);
    acc_cyc = cyc + 1;
    @(negedge clk);
    set_valid(w, 1'b0);
    lat = 1;
    while (!f_val(w) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk({nm, " latency"}, 32'(lat), 32'(exp_lat[w]));
    chk({nm, " instr"}, f_ins(w), ei);
    chk({nm, " err"}, 32'(f_err(w)), 32'(ee));
    chk({nm, " pc"}, 32'(f_pc(w)), 32'(pc));
  endtask

  task automatic load(input logic [AW-3:0] a, input logic [DW-1:0] d);
    ld_en = 1'b1;
    ld_addr = a;
    ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  initial begin
    int prev_acc;
    int n;
    int lat;
    logic seen;

    vecs[0] = '{dut: 0, pc: 11'h000, instr: 32'h02328020, err: 1'b0};
    vecs[1] = '{dut: 0, pc: 11'h004, instr: 32'h22300003, err: 1'b0};
    vecs[2] = '{dut: 1, pc: 11'h008, instr: 32'hDEADBEEF, err: 1'b0};
    vecs[3] = '{dut: 2, pc: 11'h008, instr: 32'hDEADBEEF, err: 1'b0};
    vecs[4] = '{dut: 0, pc: 11'h002, instr: 32'h00000000, err: 1'b1};
    vecs[5] = '{dut: 0, pc: 11'h400, instr: 32'h00000000, err: 1'b1};
    vecs[6] = '{dut: 2, pc: 11'h400, instr: 32'h00000000, err: 1'b1};
    vecs[7] = '{dut: 1, pc: 11'h7FF, instr: 32'h00000000, err: 1'b1};
    vecs[8] = '{dut: 0, pc: 11'h3FC, instr: 32'h00000000, err: 1'b0};

    // Reset and reset-state checks.
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst rsp_valid", 32'(a_val), 32'd0);
    chk("rst rsp_err", 32'(a_err), 32'd0);
    chk("rst rsp_instr", a_ins, 32'd0);
    chk("rst rsp_pc", 32'(a_pc), 32'd0);
    chk("rst busy", 32'(a_busy), 32'd0);
    chk("rst req_ready", 32'(a_rdy), 32'd1);
    chk("rst w3 req_ready", 32'(c_rdy), 32'd1);

    load(9'd0, 32'h02328020);
    load(9'd1, 32'h22300003);
    load(9'd2, 32'hDEADBEEF);

    // Table: back-to-back, latency sweep, error fetches.
    prev_acc = 0;
    for (int i = 0; i < 9; i++) begin
      do_fetch(vecs[i].dut, vecs[i].pc, vecs[i].instr, vecs[i].err, $sformatf("vec%0d", i));
      if (i == 1) chk("b2b accept spacing", 32'(acc_cyc - prev_acc), 32'd3);
      prev_acc = acc_cyc;
    end
    @(negedge clk);

    // Backpressure on the WAIT_CYCLES=1 instance.
    rsp_ready = 1'b0;
    req_pc = 11'h004;
    av = 1'b1;
    n = 0;
    while (!a_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("bp accepted", 32'(n < 20), 32'd1);
    @(negedge clk);
    av = 1'b0;
    lat = 1;
    while (!a_val && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("bp latency", 32'(lat), 32'd2);
    av = 1'b1;
    req_pc = 11'h008;
    for (int k = 0; k < 5; k++) begin
      chk("bp rsp_valid", 32'(a_val), 32'd1);
      chk("bp rsp_instr", a_ins, 32'h22300003);
      chk("bp rsp_pc", 32'(a_pc), 32'h004);
      chk("bp req_ready", 32'(a_rdy), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    chk("bp handshake req_ready", 32'(a_rdy), 32'd0);
    @(negedge clk);
    chk("bp after hs rsp_valid", 32'(a_val), 32'd0);
    chk("bp after hs req_ready", 32'(a_rdy), 32'd1);
    @(negedge clk);
    av = 1'b0;
    lat = 1;
    while (!a_val && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    chk("bp second latency", 32'(lat), 32'd2);
    chk("bp second instr", a_ins, 32'hDEADBEEF);
    chk("bp second pc", 32'(a_pc), 32'h008);
    @(negedge clk);

    // Loader collision on the capture edge: old word is returned.
    load(9'd5, 32'hAAAA0000);
    req_pc = 11'd20;
    av = 1'b1;
    n = 0;
    while (!a_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("col accepted", 32'(n < 20), 32'd1);
    @(negedge clk);
    av = 1'b0;
    ld_en = 1'b1;
    ld_addr = 9'd5;
    ld_data = 32'h12345678;
    @(negedge clk);
    ld_en = 1'b0;
    chk("col rsp_valid", 32'(a_val), 32'd1);
    chk("col old word", a_ins, 32'hAAAA0000);
    do_fetch(0, 11'd20, 32'h12345678, 1'b0, "col refetch");
    @(negedge clk);
    load(9'd256, 32'hFFFFFFFF);
    do_fetch(0, 11'd0, 32'h02328020, 1'b0, "oob write dropped");
    @(negedge clk);

    // Reset two cycles after accept on the WAIT_CYCLES=3 instance.
    req_pc = 11'h008;
    cv = 1'b1;
    n = 0;
    while (!c_rdy && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("rmf accepted", 32'(n < 20), 32'd1);
    @(negedge clk);
    cv = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    ld_en = 1'b1;
    ld_addr = 9'd7;
    ld_data = 32'h77777777;
    @(negedge clk);
    reset = 1'b0;
    ld_en = 1'b0;
    chk("rmf busy", 32'(c_busy), 32'd0);
    chk("rmf req_ready", 32'(c_rdy), 32'd1);
    seen = c_val;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      seen = seen | c_val;
    end
    chk("rmf no response", 32'(seen), 32'd0);
    do_fetch(2, 11'h008, 32'hDEADBEEF, 1'b0, "rmf mem kept");
    do_fetch(2, 11'h01C, 32'h77777777, 1'b0, "rmf ld in reset");
    do_fetch(0, 11'h004, 32'h22300003, 1'b0, "rmf main mem kept");
    repeat (2) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
